multi_clock_divider: RTL

//  N-channel programmable clock divider; parametrised successor of clock_divider.

---
 rtl/clkdiv_pkg.sv | 23 ++
 rtl/divider_channel.sv | 119 +++++++++++
 rtl/multi_clock_divider.sv | 75 +++++++
 3 files changed

// File: rtl/clkdiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : clkdiv_pkg
//  Purpose  : Shared types for the multi-channel clock divider.
//  Revision : 1.0 - initial release
// ============================================================================
package clkdiv_pkg;

   // Widest divisor a channel configuration can carry; DIV_WIDTH must not exceed it.
   localparam int c_DIV_W_MAX = 32;

   typedef enum logic {
      TOGGLE = 1'b0,
      PULSE  = 1'b1
   } div_mode_t;

   typedef struct packed {
      logic [c_DIV_W_MAX-1:0] div;
      div_mode_t              mode;
   } div_cfg_t;

endpackage
`default_nettype wire

// File: rtl/divider_channel.sv
`default_nettype none
// ============================================================================
//  Module   : divider_channel
//  Purpose  : One divider channel: counter, active/pending configuration and
//             glitch-free application of new settings at period boundaries.
//  Revision : 1.0 - initial release
// ============================================================================
module divider_channel
   import clkdiv_pkg::*;
#(
   parameter int                   DIV_WIDTH  = 26,
   parameter logic [DIV_WIDTH-1:0] RESET_DIV  = '0,
   parameter div_mode_t            RESET_MODE = TOGGLE
) (
   input  logic     clk,
   input  logic     reset,
   input  logic     load,
   input  div_cfg_t load_cfg,
   input  logic     sync,
   output logic     out
);

   localparam logic [DIV_WIDTH-1:0] c_ONE = DIV_WIDTH'(1);

   logic [DIV_WIDTH-1:0] r_cnt;
   logic [DIV_WIDTH-1:0] r_act_div;
   div_mode_t            r_act_mode;
   logic [DIV_WIDTH-1:0] r_pend_div;
   div_mode_t            r_pend_mode;
   logic                 r_pend_valid;
   logic                 r_out;

   logic [DIV_WIDTH-1:0] w_cnt_nxt;
   logic [DIV_WIDTH-1:0] w_act_div_nxt;
   div_mode_t            w_act_mode_nxt;
   logic [DIV_WIDTH-1:0] w_pend_div_nxt;
   div_mode_t            w_pend_mode_nxt;
   logic                 w_pend_valid_nxt;
   logic                 w_out_nxt;
   logic                 w_apply;
   logic                 w_boundary;

   // Configuration bits above DIV_WIDTH are always zero and carry no information.
   logic [c_DIV_W_MAX-1:0] w_unused_div;
   assign w_unused_div = load_cfg.div;

   assign w_boundary = (r_act_div != '0) && (r_cnt == r_act_div - c_ONE);

   // Next-state: sync first, then idle, boundary, plain counting; a load always lands last.
   always_comb begin
      w_cnt_nxt        = r_cnt;
      w_act_div_nxt    = r_act_div;
      w_act_mode_nxt   = r_act_mode;
      w_pend_div_nxt   = r_pend_div;
      w_pend_mode_nxt  = r_pend_mode;
      w_pend_valid_nxt = r_pend_valid;
      w_out_nxt        = r_out;
      w_apply          = 1'b0;

      if (sync || (r_act_div == '0)) begin
         w_cnt_nxt = '0;
         w_out_nxt = 1'b0;
         w_apply   = r_pend_valid;
      end else if (w_boundary) begin
         w_cnt_nxt = '0;
         w_apply   = r_pend_valid;
         // A stop or a mode switch restarts the output low; otherwise advance the waveform.
         if (r_pend_valid && ((r_pend_div == '0) || (r_pend_mode != r_act_mode))) begin
            w_out_nxt = 1'b0;
         end else if (r_act_mode == PULSE) begin
            w_out_nxt = 1'b1;
         end else begin
            w_out_nxt = ~r_out;
         end
      end else begin
         w_cnt_nxt = r_cnt + c_ONE;
         if (r_act_mode == PULSE) begin
            w_out_nxt = 1'b0;
         end
      end

      if (w_apply) begin
         w_act_div_nxt    = r_pend_div;
         w_act_mode_nxt   = r_pend_mode;
         w_pend_valid_nxt = 1'b0;
      end

      if (load) begin
         w_pend_div_nxt   = load_cfg.div[DIV_WIDTH-1:0];
         w_pend_mode_nxt  = load_cfg.mode;
         w_pend_valid_nxt = 1'b1;
      end
   end

   // Channel state registers with immediate reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt        <= '0;
         r_act_div    <= RESET_DIV;
         r_act_mode   <= RESET_MODE;
         r_pend_div   <= '0;
         r_pend_mode  <= TOGGLE;
         r_pend_valid <= 1'b0;
         r_out        <= 1'b0;
      end else begin
         r_cnt        <= w_cnt_nxt;
         r_act_div    <= w_act_div_nxt;
         r_act_mode   <= w_act_mode_nxt;
         r_pend_div   <= w_pend_div_nxt;
         r_pend_mode  <= w_pend_mode_nxt;
         r_pend_valid <= w_pend_valid_nxt;
         r_out        <= w_out_nxt;
      end
   end

   assign out = r_out;

endmodule
`default_nettype wire

// File: rtl/multi_clock_divider.sv
`default_nettype none
// ============================================================================
//  Module   : multi_clock_divider
//  Purpose  : N-channel programmable clock divider with per-channel divisor
//             and toggle/pulse mode, write acknowledge and global phase sync.
//  Revision : 1.0 - initial release
// ============================================================================
module multi_clock_divider
   import clkdiv_pkg::*;
#(
   parameter int                   NUM_CH     = 4,
   parameter int                   DIV_WIDTH  = 26,
   parameter logic [DIV_WIDTH-1:0] RESET_DIV  = '0,
   parameter div_mode_t            RESET_MODE = TOGGLE
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [$clog2(NUM_CH):0]  wr_chan,
   input  logic [DIV_WIDTH-1:0]     wr_div,
   input  logic                     wr_mode,
   output logic                     wr_ack,
   output logic                     wr_err,
   input  logic                     sync,
   output logic [NUM_CH-1:0]        outClk
);

   localparam int                c_CH_W   = $clog2(NUM_CH) + 1;
   localparam logic [c_CH_W-1:0] c_NUM_CH = c_CH_W'(NUM_CH);

   logic              r_ack;
   logic              r_err;
   logic              w_in_range;
   logic [NUM_CH-1:0] w_load;
   div_cfg_t          w_cfg;

   assign w_in_range = (wr_chan < c_NUM_CH);
   assign w_cfg.div  = c_DIV_W_MAX'(wr_div);
   assign w_cfg.mode = div_mode_t'(wr_mode);

   // Write handshake: one-cycle acknowledge or range error per write strobe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ack <= 1'b0;
         r_err <= 1'b0;
      end else begin
         r_ack <= wr_en && w_in_range;
         r_err <= wr_en && !w_in_range;
      end
   end

   assign wr_ack = r_ack;
   assign wr_err = r_err;

   generate
      for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
         assign w_load[i] = wr_en && (wr_chan == c_CH_W'(i));

         divider_channel #(
            .DIV_WIDTH  (DIV_WIDTH),
            .RESET_DIV  (RESET_DIV),
            .RESET_MODE (RESET_MODE)
         ) u_chan (
            .clk      (clk),
            .reset    (reset),
            .load     (w_load[i]),
            .load_cfg (w_cfg),
            .sync     (sync),
            .out      (outClk[i])
         );
      end
   endgenerate

endmodule
`default_nettype wire
